pe_cfg_loader: RTL and testbench
================================

Name: pe_cfg_loader

Overview:
- Configuration and sequencing front end for a row of PE_F-style processing elements.
- Accepts a valid/ready stream of PE instruction words and steers each word into one PE's configuration buffer by pulsing that PE's init strobe.
- Then broadcasts a run window of programmable length so every PE replays its buffer.
- Sits directly upstream of the PEs; drives their PE_inst, init, run and a PE-domain reset.

Parameters:
- PE_INST_W, 28, instruction word width (opcode 4 + switch 18 + c2 + c1 + reg_file_sel 4).
- NUM_PE, 4, number of PEs served.
- BUF_DEPTH, 8, config buffer depth per PE; equals the PE buffer_depth.
- CNT_W, 8, width of run_len and the internal counters; must satisfy 2^CNT_W > NUM_PE*BUF_DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (rst=0 resets on the clk edge).
- load_start  in  1  one-cycle request to begin a load.
- run_start  in  1  one-cycle request to begin a run.
- run_len  in  CNT_W  run length in cycles, sampled with run_start.
- cfg_valid  in  1  instruction word valid.
- cfg_data  in  PE_INST_W  instruction word.
- cfg_last  in  1  marks the final word of a load.
- cfg_ready  out  1  loader accepts a word.
- pe_inst  out  PE_INST_W  registered word, shared by all PEs.
- pe_init  out  NUM_PE  one-hot init strobe, bit p targets PE p.
- pe_run  out  1  broadcast run.
- pe_rst  out  1  active-high reset to the PEs.
- busy  out  1  high in LOAD or RUN.
- loaded  out  1  high in READY.
- done  out  1  one-cycle pulse at run completion.
- err  out  1  sticky protocol error, cleared only by rst or load_start.

Behaviour:
- Reset values (rst=0): state IDLE; cfg_ready=0, pe_inst=0, pe_init=0, pe_run=0, busy=0, loaded=0, done=0, err=0; pe_rst=1.
- All outputs are registered.
- States: IDLE, CLR, LOAD, READY, RUN.
- Word order is PE-major: PE0 slot0..slot BUF_DEPTH-1, then PE1, and so on. Total words W = NUM_PE*BUF_DEPTH.
- IDLE:
  - load_start -> CLR, and err clears.
  - run_start -> err=1, state unchanged.
- CLR:
  - Lasts exactly 1 cycle with pe_rst=1, which resets each PE's init_count and run_count.
  - Then -> LOAD with word counter wc=0.
  - pe_rst=0 in all other states after reset is released.
- LOAD:
  - cfg_ready=1.
  - A word is accepted when cfg_valid & cfg_ready.
  - An accepted word at cycle t gives pe_inst=cfg_data and pe_init[wc/BUF_DEPTH]=1 at t+1, for exactly one cycle.
  - pe_init=0 in any cycle following no acceptance.
  - wc increments per accept.
  - Accept with wc=W-1 and cfg_last=1 -> READY.
  - cfg_last=1 with wc<W-1, or cfg_last=0 with wc=W-1 -> err=1, abort to IDLE. The aborted word's init strobe is still issued.
  - load_start and run_start are ignored in LOAD.
- READY:
  - loaded=1.
  - load_start -> CLR. load_start wins if asserted together with run_start.
  - run_start -> RUN with rc = min(run_len, BUF_DEPTH). The clamp prevents a PE from reading past its buffer.
  - run_len=0 -> no pe_run cycles; done pulses the next cycle and the state returns to READY.
- RUN:
  - run_start at cycle t gives pe_run=1 on cycles t+1..t+rc.
  - done=1 on cycle t+rc+1, then -> READY.
  - Re-running from READY without a reload is permitted but does not rewind the PEs' run_count. Software must reload, via the CLR reset, before replaying.
  - load_start and run_start are ignored in RUN.
- cfg_valid outside LOAD: cfg_ready=0, the word is not consumed, no effect.
- Reset asserted mid-LOAD or mid-RUN: all outputs return to their reset values on the next edge. pe_rst=1 guarantees the PEs are also cleared. No partial strobes follow.
- Counters never wrap: wc is bounded by W-1 and rc by BUF_DEPTH.

Test Plan:
- Full load, defaults: load_start, then 32 back-to-back words 0x1000000..0x100001F with cfg_last on word 31 -> pe_rst pulses 1 cycle; pe_init=0001 for words 0-7, 0010 for 8-15, 0100 for 16-23, 1000 for 24-31; each pe_inst equals its word one cycle after acceptance; loaded=1.
- Backpressure: cfg_valid toggled every other cycle during a load -> pe_init pulses only on cycles following acceptance; all 32 words are delivered in order with no duplicates.
- Run clamp: from READY, run_start with run_len=20 -> pe_run high for exactly 8 cycles; done on the 9th cycle after run_start; loaded=1 afterwards.
- Protocol errors:
  - cfg_last on word 5 -> err=1, state IDLE, loaded=0.
  - Later load_start -> err clears.
  - run_start in IDLE -> err=1, pe_run stays 0.
- Simultaneous requests and run_len=0: load_start with run_start in READY -> CLR taken, pe_run stays 0. run_len=0 -> no pe_run, done the next cycle.
- Reset mid-run: rst=0 on the 3rd pe_run cycle -> the next edge gives pe_run=0, pe_rst=1, busy=0, done never pulses.

Source files
------------

// File: rtl/pe_cfg_loader.sv
// Configuration front end for a row of PEs: steers a valid/ready instruction stream
// into per-PE config buffers via one-hot init strobes, then broadcasts a bounded run window.
module pe_cfg_loader #(
  parameter int PE_INST_W = 28,
  parameter int NUM_PE    = 4,
  parameter int BUF_DEPTH = 8,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 run_start,
  input  logic [CNT_W-1:0]     run_len,
  input  logic                 cfg_valid,
  input  logic [PE_INST_W-1:0] cfg_data,
  input  logic                 cfg_last,
  output logic                 cfg_ready,
  output logic [PE_INST_W-1:0] pe_inst,
  output logic [NUM_PE-1:0]    pe_init,
  output logic                 pe_run,
  output logic                 pe_rst,
  output logic                 busy,
  output logic                 loaded,
  output logic                 done,
  output logic                 err
);

  localparam int W = NUM_PE * BUF_DEPTH;
  localparam logic [CNT_W-1:0] WC_LAST   = CNT_W'(W - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(BUF_DEPTH);

  typedef enum logic [2:0] {IDLE, CLR, LOAD, READY, RUN} state_t;

  state_t                 state, state_n;
  logic [CNT_W-1:0]       wc, wc_n, slot, slot_n, rc, rc_n;
  logic [NUM_PE-1:0]      pe_oh, pe_oh_n;
  logic [NUM_PE-1:0]      pe_init_n;
  logic [PE_INST_W-1:0]   pe_inst_n;
  logic                   err_n, done_n, pe_run_n;
  logic                   accept;
  logic [CNT_W-1:0]       run_sat;

  // A PE must never replay past the end of its buffer.
  function automatic logic [CNT_W-1:0] sat_run_len(input logic [CNT_W-1:0] len);
    return (len > DEPTH_C) ? DEPTH_C : len;
  endfunction

  assign accept  = cfg_valid & cfg_ready;
  assign run_sat = sat_run_len(run_len);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      wc    <= '0;
      slot  <= '0;
      rc    <= '0;
      pe_oh <= '0;
    end else begin
      state <= state_n;
      wc    <= wc_n;
      slot  <= slot_n;
      rc    <= rc_n;
      pe_oh <= pe_oh_n;
    end
  end

  always_comb begin
    state_n   = state;
    wc_n      = wc;
    slot_n    = slot;
    rc_n      = rc;
    pe_oh_n   = pe_oh;
    pe_init_n = '0;
    pe_inst_n = pe_inst;
    err_n     = err;
    done_n    = 1'b0;
    pe_run_n  = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          state_n = CLR;
          err_n   = 1'b0;
        end else if (run_start) begin
          err_n = 1'b1;
        end
      end
      CLR: begin
        state_n = LOAD;
        wc_n    = '0;
        slot_n  = '0;
        pe_oh_n = NUM_PE'(1);
      end
      LOAD: begin
        if (accept) begin
          pe_inst_n = cfg_data;
          pe_init_n = pe_oh;
          wc_n      = (wc == WC_LAST) ? wc : wc + 1'b1;
          if (slot == SLOT_LAST) begin
            slot_n  = '0;
            pe_oh_n = pe_oh << 1;
          end else begin
            slot_n = slot + 1'b1;
          end
          // cfg_last must coincide exactly with the final word of the row.
          if (cfg_last != (wc == WC_LAST)) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else if (cfg_last) begin
            state_n = READY;
          end
        end
      end
      READY: begin
        if (load_start) begin
          state_n = CLR;
          err_n   = 1'b0;
        end else if (run_start) begin
          if (run_sat == '0) begin
            done_n = 1'b1;
          end else begin
            state_n  = RUN;
            pe_run_n = 1'b1;
            rc_n     = run_sat - 1'b1;
          end
        end
      end
      RUN: begin
        // rc counts the pe_run cycles still owed after the current one.
        if (rc != '0) begin
          pe_run_n = 1'b1;
          rc_n     = rc - 1'b1;
        end else begin
          done_n  = 1'b1;
          state_n = READY;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cfg_ready <= 1'b0;
      pe_inst   <= '0;
      pe_init   <= '0;
      pe_run    <= 1'b0;
      pe_rst    <= 1'b1;
      busy      <= 1'b0;
      loaded    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      cfg_ready <= (state_n == LOAD);
      pe_inst   <= pe_inst_n;
      pe_init   <= pe_init_n;
      pe_run    <= pe_run_n;
      pe_rst    <= (state_n == CLR);
      busy      <= (state_n == LOAD) || (state_n == RUN);
      loaded    <= (state_n == READY);
      done      <= done_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_pe_cfg_loader.sv
// Directed bench for pe_cfg_loader: scoreboarded init strobes plus run/error/reset scenarios.
module tb_pe_cfg_loader;
  localparam int PE_INST_W = 28;
  localparam int NUM_PE    = 4;
  localparam int BUF_DEPTH = 8;
  localparam int CNT_W     = 8;
  localparam logic [27:0] BASE = 28'h1000000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load_start = 1'b0;
  logic run_start = 1'b0;
  logic [CNT_W-1:0] run_len = '0;
  logic cfg_valid = 1'b0;
  logic [PE_INST_W-1:0] cfg_data = '0;
  logic cfg_last = 1'b0;
  logic cfg_ready;
  logic [PE_INST_W-1:0] pe_inst;
  logic [NUM_PE-1:0] pe_init;
  logic pe_run, pe_rst, busy, loaded, done, err;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_w;

  always #5 clk = ~clk;

  pe_cfg_loader #(
    .PE_INST_W(PE_INST_W), .NUM_PE(NUM_PE), .BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .run_start(run_start),
    .run_len(run_len), .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .cfg_ready(cfg_ready), .pe_inst(pe_inst), .pe_init(pe_init), .pe_run(pe_run),
    .pe_rst(pe_rst), .busy(busy), .loaded(loaded), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every nonzero init strobe must match the oldest outstanding accepted word.
  always @(negedge clk) begin
    if (pe_init !== '0) begin
      check("init_expected", (sb.size() != 0), 1'b1);
      if (sb.size() != 0) begin
        exp_w = sb.pop_front();
        check("pe_init", pe_init, exp_w[31:28]);
        check("pe_inst", pe_inst, exp_w[27:0]);
      end
    end
  end

  task automatic start_load(input logic with_run);
    load_start = 1'b1;
    run_start  = with_run;
    run_len    = 8'd5;
    tick();
    load_start = 1'b0;
    run_start  = 1'b0;
    check("clr_pe_rst", pe_rst, 1'b1);
    check("clr_ready", cfg_ready, 1'b0);
    check("clr_pe_run", pe_run, 1'b0);
    check("clr_loaded", loaded, 1'b0);
    check("clr_err", err, 1'b0);
    tick();
    check("load_pe_rst", pe_rst, 1'b0);
    check("load_ready", cfg_ready, 1'b1);
    check("load_busy", busy, 1'b1);
  endtask

  task automatic load_words(input int n, input int last_idx, input bit gaps);
    int i;
    int cyc;
    i = 0;
    cyc = 0;
    while (i < n) begin
      if (gaps && (cyc % 2 == 1)) begin
        cfg_valid = 1'b0;
      end else begin
        cfg_valid = 1'b1;
        cfg_data  = BASE + 28'(i);
        cfg_last  = (i == last_idx);
        sb.push_back({4'(1 << (i / BUF_DEPTH)), BASE + 28'(i)});
        i++;
      end
      cyc++;
      tick();
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic run_count(input logic [CNT_W-1:0] len, input int cycles,
                           output int runs, output int done_at);
    run_len   = len;
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    runs = 0;
    done_at = 0;
    for (int n = 1; n <= cycles; n++) begin
      if (pe_run) runs++;
      if (done && done_at == 0) done_at = n;
      tick();
    end
  endtask

  initial begin
    int runs;
    int done_at;
    int dcount;

    tick();
    tick();
    check("rst_cfg_ready", cfg_ready, 1'b0);
    check("rst_pe_inst", pe_inst, 28'h0);
    check("rst_pe_init", pe_init, 4'h0);
    check("rst_pe_run", pe_run, 1'b0);
    check("rst_pe_rst", pe_rst, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_loaded", loaded, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b1;
    tick();
    check("idle_pe_rst", pe_rst, 1'b0);

    // Full back-to-back load
    start_load(1'b0);
    load_words(32, 31, 1'b0);
    tick();
    check("full_drained", sb.size(), 0);
    check("full_loaded", loaded, 1'b1);
    check("full_busy", busy, 1'b0);
    check("full_ready_low", cfg_ready, 1'b0);
    check("full_err", err, 1'b0);

    // Run clamp, short run, zero-length run
    run_count(8'd20, 12, runs, done_at);
    check("clamp_runs", runs, 8);
    check("clamp_done_at", done_at, 9);
    check("clamp_loaded", loaded, 1'b1);
    run_count(8'd3, 6, runs, done_at);
    check("run3_runs", runs, 3);
    check("run3_done_at", done_at, 4);
    run_count(8'd0, 3, runs, done_at);
    check("run0_runs", runs, 0);
    check("run0_done_at", done_at, 1);
    check("run0_loaded", loaded, 1'b1);

    // Simultaneous load_start + run_start, then reload with backpressure
    start_load(1'b1);
    load_words(32, 31, 1'b1);
    tick();
    check("bp_drained", sb.size(), 0);
    check("bp_loaded", loaded, 1'b1);

    // Reset during the third pe_run cycle
    run_len   = 8'd8;
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    tick();
    tick();
    check("mid_pe_run", pe_run, 1'b1);
    rst = 1'b0;
    tick();
    check("mid_rst_pe_run", pe_run, 1'b0);
    check("mid_rst_pe_rst", pe_rst, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_loaded", loaded, 1'b0);
    check("mid_rst_pe_inst", pe_inst, 28'h0);
    rst = 1'b1;
    dcount = 0;
    runs = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) dcount++;
      if (pe_run) runs++;
    end
    check("mid_no_done", dcount, 0);
    check("mid_no_run", runs, 0);

    // Early cfg_last aborts the load
    start_load(1'b0);
    load_words(6, 5, 1'b0);
    tick();
    check("early_err", err, 1'b1);
    check("early_loaded", loaded, 1'b0);
    check("early_busy", busy, 1'b0);
    check("early_ready", cfg_ready, 1'b0);
    check("early_drained", sb.size(), 0);
    cfg_valid = 1'b1;
    cfg_data  = 28'hABCDEF0;
    tick();
    tick();
    check("idle_valid_ready", cfg_ready, 1'b0);
    cfg_valid = 1'b0;

    // load_start clears err; missing cfg_last on the final word aborts again
    start_load(1'b0);
    load_words(32, -1, 1'b0);
    tick();
    check("nolast_err", err, 1'b1);
    check("nolast_loaded", loaded, 1'b0);
    check("nolast_drained", sb.size(), 0);

    // run_start in IDLE flags an error and never runs
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("idle_err_clear", err, 1'b0);
    run_len   = 8'd4;
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    check("idle_run_err", err, 1'b1);
    check("idle_run_pe_run", pe_run, 1'b0);
    tick();
    check("idle_run_pe_run2", pe_run, 1'b0);
    check("idle_err_sticky", err, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
